axis_axil_master_bridge: RTL
============================

Name: axis_axil_master_bridge

Overview:
AXI-Lite master bridge between AXI-Stream and a memory-mapped AXI-Lite slave. Each word accepted on s_axis is written to a fixed register address. On request, the block reads a fixed register address and pushes the returned word out on m_axis. It sits on the host side of an AXI-Lite link and drives stream-to-register mailboxes in peripheral blocks.

Parameters:
AXI_DATA_WIDTH, 32, data width of stream and AXI-Lite data buses
AXI_ADDR_WIDTH, 32, AXI-Lite address width
WR_ADDR, 32'h0000_0001, target address for every write transaction
RD_ADDR, 32'h0000_0001, target address for every read transaction
ERR_CNT_WIDTH, 8, width of the saturating error counters

Ports:
aclk  input  1  clock
aresetn  input  1  asynchronous active-low reset
s_axis  interface axis_if.s_axis  AXI_DATA_WIDTH  stream words to be written (tdata, tvalid, tready)
m_axis  interface axis_if.m_axis  AXI_DATA_WIDTH  stream of words read back
m_axil  interface axil_if.m_axil  -  AXI-Lite master (aw*, w*, b*, ar*, r*)
rd_req  input  1  level; while high, read transactions are issued back-to-back
wr_err_cnt  output  ERR_CNT_WIDTH  count of non-OKAY bresp, saturating
rd_err_cnt  output  ERR_CNT_WIDTH  count of non-OKAY rresp, saturating

Behaviour:
- Reset is asynchronous and active-low. It is applied on the falling edge of aresetn and released synchronously to aclk.
- Reset values: all valid and ready outputs are 0, tdata/awaddr/wdata/araddr are 0, wstrb is all-ones, awprot/arprot are 0, both counters are 0, both FSMs are idle.
- Reset during a transaction aborts it immediately. No partial transfer resumes after reset.
- The write and read FSMs are independent and may run concurrently.
- Write FSM states and transitions:
  - W_IDLE: s_axis.tready=1. On tvalid&tready, latch tdata, drop tready and go to W_REQ. Exactly one word is accepted per transaction.
  - W_REQ: awvalid=1, awaddr=WR_ADDR, wvalid=1, wdata=latched word. Each valid drops independently on its own handshake. When both handshakes are done (same or different cycles), go to W_RESP.
  - W_RESP: bready=1. On bvalid: if bresp!=2'b00, increment wr_err_cnt unless it is all-ones. Then go to W_IDLE.
- Write latency: s_axis handshake at cycle N gives awvalid/wvalid high at cycle N+1. The next s_axis word can be accepted no earlier than the cycle after the b handshake.
- Read FSM states and transitions:
  - R_IDLE: if rd_req, go to R_ADDR.
  - R_ADDR: arvalid=1, araddr=RD_ADDR, held until arready, then go to R_DATA.
  - R_DATA: rready=1. On rvalid: if rresp==2'b00, latch rdata into m_axis.tdata, set tvalid=1 and go to R_PUSH. Otherwise increment rd_err_cnt (saturating), emit no stream word and go to R_IDLE.
  - R_PUSH: hold tdata and tvalid stable until tready. On the handshake, tvalid=0, tdata=0, go to R_IDLE.
- rd_req is sampled only in R_IDLE. Deasserting it mid-transaction does not abort the transaction.
- Backpressure on m_axis stalls the read path only. The write path is unaffected.
- All AXI valids, once asserted, stay high with stable payload until their handshake.
- Counters hold at 2^ERR_CNT_WIDTH-1 once saturated.

Decomposition:
- Shared package axil_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - state enums wr_state_t {W_IDLE, W_REQ, W_RESP} and rd_state_t {R_IDLE, R_ADDR, R_DATA, R_PUSH}.
- One sub-module, sat_counter (parameter WIDTH, inputs inc and clear), instantiated for each of the two error counters.

Test Plan:
- Single write: s_axis word 32'hDEADBEEF, slave grants awready and wready in the same cycle and returns bresp OKAY -> one AW/W transaction at addr 1 with wdata DEADBEEF, wstrb 4'hF, wr_err_cnt stays 0.
- Split handshake: slave asserts awready 3 cycles before wready -> awvalid drops after its handshake, wvalid stays high until its own handshake, exactly one b handshake, then tready returns high.
- Error response: slave answers reads with rresp 2'b10 -> no m_axis word, rd_err_cnt=1. After 300 error writes, wr_err_cnt holds at 255.
- Read with backpressure: rd_req=1, slave returns 32'h1234_5678 OKAY, m_axis.tready held low 5 cycles -> tdata 12345678 stays stable with tvalid high for 5 cycles, then one transfer. No new araddr is issued before that transfer.
- Concurrent paths: stream words A and B are written while rd_req stays high -> writes complete in order A, B, and reads proceed interleaved without loss.
- Mid-transaction reset: aresetn pulled low while awvalid and arvalid are high -> all valids go to 0 immediately, with no clock edge needed. After release, the FSMs are idle and the next s_axis word starts a fresh write.

Source files
------------

// File: rtl/axis_axil_master_bridge_pkg.sv
// Shared response/state types for the AXI-Stream to AXI-Lite master bridge.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_PUSH = 2'd3
  } rd_state_t;

  // Anything other than OKAY counts as an error, including EXOKAY on AXI-Lite.
  function automatic logic resp_is_err(input resp_t resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/axis_axil_master_bridge_if.sv
// Stream and AXI-Lite bundles used by the bridge, with master/slave views.
interface axis_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport s_axis (input tdata, input tvalid, output tready);
  modport m_axis (output tdata, output tvalid, input tready);
endinterface

interface axil_if
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  resp_t                   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  resp_t                   rresp;
  logic                    rvalid;
  logic                    rready;

  modport m_axil (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );
  modport s_axil (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axis_axil_master_bridge_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_r;

  // Count register: clear wins over increment, increment stops at CNT_MAX
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/axis_axil_master_bridge.sv
// AXI-Stream to AXI-Lite master bridge: each stream word becomes a register write;
// while rd_req is high, register reads are issued and pushed out as stream words.
module axis_axil_master_bridge
  import axil_pkg::*;
#(
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0] WR_ADDR        = AXI_ADDR_WIDTH'(32'h0000_0001),
  parameter logic [AXI_ADDR_WIDTH-1:0] RD_ADDR        = AXI_ADDR_WIDTH'(32'h0000_0001),
  parameter int                        ERR_CNT_WIDTH  = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axis_if.s_axis                   s_axis,
  axis_if.m_axis                   m_axis,
  axil_if.m_axil                   m_axil,
  input  logic                     rd_req,
  output logic [ERR_CNT_WIDTH-1:0] wr_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] rd_err_cnt
);
  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  wr_state_t                 wr_state_r, wr_state_s;
  logic                      s_tready_r, s_tready_s;
  logic                      awvalid_r, awvalid_s;
  logic                      wvalid_r, wvalid_s;
  logic                      bready_r, bready_s;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_r, awaddr_s;
  logic [AXI_DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic                      wr_err_inc_s;

  rd_state_t                 rd_state_r, rd_state_s;
  logic                      arvalid_r, arvalid_s;
  logic                      rready_r, rready_s;
  logic [AXI_ADDR_WIDTH-1:0] araddr_r, araddr_s;
  logic [AXI_DATA_WIDTH-1:0] m_tdata_r, m_tdata_s;
  logic                      m_tvalid_r, m_tvalid_s;
  logic                      rd_err_inc_s;

  // Write-path state and registered write-channel outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_r <= W_IDLE;
      s_tready_r <= 1'b0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      bready_r   <= 1'b0;
      awaddr_r   <= {AXI_ADDR_WIDTH{1'b0}};
      wdata_r    <= {AXI_DATA_WIDTH{1'b0}};
    end else begin
      wr_state_r <= wr_state_s;
      s_tready_r <= s_tready_s;
      awvalid_r  <= awvalid_s;
      wvalid_r   <= wvalid_s;
      bready_r   <= bready_s;
      awaddr_r   <= awaddr_s;
      wdata_r    <= wdata_s;
    end
  end

  // Write FSM next-state: one stream word per AW/W/B sequence
  always_comb begin
    wr_state_s   = wr_state_r;
    s_tready_s   = s_tready_r;
    awvalid_s    = awvalid_r;
    wvalid_s     = wvalid_r;
    bready_s     = bready_r;
    awaddr_s     = awaddr_r;
    wdata_s      = wdata_r;
    wr_err_inc_s = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (s_axis.tvalid && s_tready_r) begin
          s_tready_s = 1'b0;
          awvalid_s  = 1'b1;
          wvalid_s   = 1'b1;
          awaddr_s   = WR_ADDR;
          wdata_s    = s_axis.tdata;
          wr_state_s = W_REQ;
        end else begin
          s_tready_s = 1'b1;
        end
      end
      W_REQ: begin
        // AW and W retire independently; move on once both are gone.
        awvalid_s = awvalid_r & ~m_axil.awready;
        wvalid_s  = wvalid_r & ~m_axil.wready;
        if (!awvalid_s && !wvalid_s) begin
          bready_s   = 1'b1;
          wr_state_s = W_RESP;
        end else begin
          wr_state_s = W_REQ;
        end
      end
      W_RESP: begin
        if (m_axil.bvalid && bready_r) begin
          bready_s     = 1'b0;
          s_tready_s   = 1'b1;
          wr_err_inc_s = resp_is_err(m_axil.bresp);
          wr_state_s   = W_IDLE;
        end else begin
          wr_state_s = W_RESP;
        end
      end
      default: begin
        wr_state_s = W_IDLE;
        s_tready_s = 1'b0;
        awvalid_s  = 1'b0;
        wvalid_s   = 1'b0;
        bready_s   = 1'b0;
      end
    endcase
  end

  // Read-path state and registered read-channel / stream outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_r <= R_IDLE;
      arvalid_r  <= 1'b0;
      rready_r   <= 1'b0;
      araddr_r   <= {AXI_ADDR_WIDTH{1'b0}};
      m_tdata_r  <= {AXI_DATA_WIDTH{1'b0}};
      m_tvalid_r <= 1'b0;
    end else begin
      rd_state_r <= rd_state_s;
      arvalid_r  <= arvalid_s;
      rready_r   <= rready_s;
      araddr_r   <= araddr_s;
      m_tdata_r  <= m_tdata_s;
      m_tvalid_r <= m_tvalid_s;
    end
  end

  // Read FSM next-state: rd_req only matters in R_IDLE
  always_comb begin
    rd_state_s   = rd_state_r;
    arvalid_s    = arvalid_r;
    rready_s     = rready_r;
    araddr_s     = araddr_r;
    m_tdata_s    = m_tdata_r;
    m_tvalid_s   = m_tvalid_r;
    rd_err_inc_s = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (rd_req) begin
          arvalid_s  = 1'b1;
          araddr_s   = RD_ADDR;
          rd_state_s = R_ADDR;
        end else begin
          rd_state_s = R_IDLE;
        end
      end
      R_ADDR: begin
        if (arvalid_r && m_axil.arready) begin
          arvalid_s  = 1'b0;
          rready_s   = 1'b1;
          rd_state_s = R_DATA;
        end else begin
          rd_state_s = R_ADDR;
        end
      end
      R_DATA: begin
        if (m_axil.rvalid && rready_r) begin
          rready_s = 1'b0;
          if (!resp_is_err(m_axil.rresp)) begin
            m_tdata_s  = m_axil.rdata;
            m_tvalid_s = 1'b1;
            rd_state_s = R_PUSH;
          end else begin
            rd_err_inc_s = 1'b1;
            rd_state_s   = R_IDLE;
          end
        end else begin
          rd_state_s = R_DATA;
        end
      end
      R_PUSH: begin
        if (m_axis.tready) begin
          m_tvalid_s = 1'b0;
          m_tdata_s  = {AXI_DATA_WIDTH{1'b0}};
          rd_state_s = R_IDLE;
        end else begin
          rd_state_s = R_PUSH;
        end
      end
      default: begin
        rd_state_s = R_IDLE;
        arvalid_s  = 1'b0;
        rready_s   = 1'b0;
        m_tvalid_s = 1'b0;
        m_tdata_s  = {AXI_DATA_WIDTH{1'b0}};
      end
    endcase
  end

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_wr_err_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (wr_err_inc_s),
    .clear   (1'b0),
    .count   (wr_err_cnt)
  );

  sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_rd_err_cnt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (rd_err_inc_s),
    .clear   (1'b0),
    .count   (rd_err_cnt)
  );

  assign s_axis.tready  = s_tready_r;
  assign m_axis.tdata   = m_tdata_r;
  assign m_axis.tvalid  = m_tvalid_r;
  assign m_axil.awaddr  = awaddr_r;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_r;
  assign m_axil.wdata   = wdata_r;
  assign m_axil.wstrb   = {STRB_WIDTH{1'b1}};
  assign m_axil.wvalid  = wvalid_r;
  assign m_axil.bready  = bready_r;
  assign m_axil.araddr  = araddr_r;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_r;
  assign m_axil.rready  = rready_r;

endmodule
